// File: rtl/mem_dma.sv
// Word-granular copy/fill DMA initiator for the native mem_valid/mem_ready bus.
// Copy mode alternates one read and one write per word; fill mode issues only
// writes of a latched constant. A per-request watchdog aborts a stalled job.
module mem_dma #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             abort,
  input  logic             fill,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  // Last count value before the watchdog fires; valid stays high TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q, fill_data_q;
  logic             fill_q;
  logic [LEN_W-1:0] remain_q, words_q;
  logic [15:0]      tmo_q;
  logic             err_q, done_q;
  logic             xfer, tmo_hit, last;

  assign xfer    = mem_valid & mem_ready;
  assign tmo_hit = mem_valid & ~mem_ready & (tmo_q == TMO_LAST);
  assign last    = (remain_q == LEN_W'(1));

  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;
  assign mem_instr  = 1'b0;

  // State register; async reset puts the engine back in IDLE immediately.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: completion wins over timeout on the same edge.
  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (len == '0) ? FIN : (fill ? WR : RD);
      RD: begin
        if (xfer)         state_d = abort ? FIN : WR;
        else if (tmo_hit) state_d = FIN;
      end
      WR: begin
        if (xfer)         state_d = (last || abort) ? FIN : (fill_q ? WR : RD);
        else if (tmo_hit) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from state; they only change on an edge, so they hold while waiting.
  always_comb begin
    busy      = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    unique case (state_q)
      RD: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = src_q;
      end
      WR: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = fill_q ? fill_data_q : data_q;
        mem_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  // Job datapath: latch parameters at start, advance pointers and counters per completion.
  // NOTE: the data/parameter registers are reset too, so bus outputs read as 0 after reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      fill_data_q <= '0;
      fill_q      <= 1'b0;
      remain_q    <= '0;
      words_q     <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == FIN);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q       <= src_adr & 32'hFFFF_FFFC;
            dst_q       <= dst_adr & 32'hFFFF_FFFC;
            remain_q    <= len;
            fill_q      <= fill;
            fill_data_q <= fill_data;
            words_q     <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
          end
        end
        RD, WR: begin
          if (xfer) tmo_q <= '0;
          else      tmo_q <= tmo_q + 16'd1;
          if (tmo_hit) err_q <= 1'b1;
          if (xfer && state_q == RD) begin
            data_q <= mem_rdata;
            src_q  <= src_q + 32'd4;
          end
          if (xfer && state_q == WR) begin
            dst_q    <= dst_q + 32'd4;
            words_q  <= words_q + LEN_W'(1);
            remain_q <= remain_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: a transaction-list model predicts every bus
// access of a job; a responder with configurable latency serves the bus, and a
// monitor compares each completed transaction against the predicted list.
module tb_mem_dma;

  localparam int LEN_W = 16;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             n_reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             fill = 1'b0;
  logic [31:0]      src_adr = '0;
  logic [31:0]      dst_adr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [31:0]      fill_data = '0;
  logic             busy, done, err;
  logic [LEN_W-1:0] words_done;
  logic             mem_valid, mem_instr;
  logic             mem_ready = 1'b0;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [31:0]      mem_rdata = '0;

  mem_dma #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .abort(abort), .fill(fill),
    .src_adr(src_adr), .dst_adr(dst_adr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_words, exp_cycles, cycles_last;
  bit   exp_err;

  // responder configuration
  int   lat_min = 1, lat_max = 1, lat_cur = 0, seen = 0;
  bit   never_rdy = 0;
  int   abort_idx = -1;
  int   tx_idx = 0;
  bit   resp_abort = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents of source memory as seen by the responder.
  function automatic logic [31:0] src_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Predict the bus transactions, word count, error and duration of one job.
  task automatic build_model(input bit f, input logic [31:0] s, input logic [31:0] d,
                             input int n, input logic [31:0] fd, input int ab,
                             input bit never, input int lat_fixed);
    exp_t e;
    logic [31:0] sa, da;
    exp_q.delete();
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      if (!f) begin
        e.addr = sa; e.we = 1'b0; e.wdata = '0;
        exp_q.push_back(e);
      end
      e.addr = da; e.we = 1'b1; e.wdata = f ? fd : src_word(sa);
      exp_q.push_back(e);
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
    if (ab >= 0) while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
    if (never) exp_q.delete();
    exp_words = 0;
    foreach (exp_q[i]) if (exp_q[i].we) exp_words++;
    exp_err = never && (n > 0);
    if (never)              exp_cycles = TMO + 2;
    else if (lat_fixed >= 0) exp_cycles = exp_q.size() * (lat_fixed + 1) + 2;
    else                    exp_cycles = -1;
  endtask

  // Responder: ready pulses lat_cur cycles after valid is first seen.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!n_reset) begin
        mem_ready = 1'b0;
        seen = 0;
        if (resp_abort) begin abort = 1'b0; resp_abort = 0; end
      end else begin
        if (mem_ready) begin
          mem_ready = 1'b0;
          seen = 0;
          tx_idx++;
          if (resp_abort) begin abort = 1'b0; resp_abort = 0; end
        end
        mem_rdata = $urandom;
        if (mem_valid && !never_rdy) begin
          seen++;
          if (seen == 1) lat_cur = $urandom_range(lat_max, lat_min);
          if (seen > lat_cur) begin
            mem_ready = 1'b1;
            mem_rdata = src_word(mem_addr);
            if (tx_idx == abort_idx) begin abort = 1'b1; resp_abort = 1; end
          end
        end
      end
    end
  end

  // Monitor: per-cycle invariants and transaction comparison against the model.
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  bit          pend_v = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_reset) begin
        check("instr_zero", mem_instr, 1'b0);
        check("done_busy_excl", done & busy, 1'b0);
        if (mem_valid && pend_v) begin
          check("stable_addr", mem_addr, p_addr);
          check("stable_wdata", mem_wdata, p_wdata);
          check("stable_wstrb", mem_wstrb, p_wstrb);
        end
        if (mem_valid && mem_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_tx", mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("tx_addr", mem_addr, e.addr);
            check("tx_wstrb", mem_wstrb, e.we ? 4'b1111 : 4'b0000);
            if (e.we) check("tx_wdata", mem_wdata, e.wdata);
          end
        end
        pend_v  = mem_valid && !mem_ready;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_wstrb = mem_wstrb;
      end else begin
        pend_v = 0;
      end
    end
  end

  // Start a job, disturb inputs while busy, wait (bounded) for done and check the result.
  task automatic run_job(input bit f, input logic [31:0] s, input logic [31:0] d,
                         input int n, input logic [31:0] fd, input int ab,
                         input bit never, input int lo, input int hi, input bit ab_start);
    int cyc, vcnt;
    bit seen_done;
    lat_min = lo; lat_max = hi; never_rdy = never; abort_idx = ab; tx_idx = 0;
    @(negedge clk);
    start = 1'b1; fill = f; src_adr = s; dst_adr = d; len = LEN_W'(n); fill_data = fd;
    if (ab_start) abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ab_start) abort = 1'b0;
    fill = ~f; src_adr = $urandom; dst_adr = $urandom; len = LEN_W'($urandom); fill_data = $urandom;
    cyc = 0; vcnt = 0; seen_done = 0;
    while (cyc < 3000 && !seen_done) begin
      @(negedge clk);
      cyc++;
      if (mem_valid) vcnt++;
      if (cyc == 1) check("err_clear_on_start", err, 1'b0);
      if (done) seen_done = 1;
      else if (cyc == 3 && busy) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check("done_seen", seen_done, 1'b1);
    check("words_done", words_done, LEN_W'(exp_words));
    check("err", err, exp_err);
    check("busy_at_done", busy, 1'b0);
    check("tx_left", exp_q.size(), 0);
    check("valid_cycles", vcnt, cyc - 2);
    if (exp_cycles >= 0) check("job_cycles", cyc, exp_cycles);
    cycles_last = cyc;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    never_rdy = 0;
    abort_idx = -1;
  endtask

  initial begin
    bit          f;
    int          n, ab, lo, hi;
    logic [31:0] s, d, fd;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_words", words_done, '0);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", mem_wstrb, 4'b0000);
    check("rst_instr", mem_instr, 1'b0);
    n_reset = 1'b1;

    // copy of three words
    build_model(0, 32'h0002_0000, 32'h0000_0100, 3, 32'h0, -1, 0, 1);
    check("pin_copy_n", exp_q.size(), 6);
    check("pin_copy_r0", exp_q[0].addr, 32'h0002_0000);
    check("pin_copy_w0", exp_q[1].addr, 32'h0000_0100);
    check("pin_copy_r2", exp_q[4].addr, 32'h0002_0008);
    check("pin_copy_w2", exp_q[5].addr, 32'h0000_0108);
    run_job(0, 32'h0002_0000, 32'h0000_0100, 3, 32'h0, -1, 0, 1, 1, 0);
    check("copy_cycles_14", cycles_last, 14);

    // fill of four words
    build_model(1, 32'h0, 32'h0000_0200, 4, 32'hDEAD_BEEF, -1, 0, 1);
    check("pin_fill_n", exp_q.size(), 4);
    check("pin_fill_w3", exp_q[3].addr, 32'h0000_020C);
    check("pin_fill_d", exp_q[3].wdata, 32'hDEAD_BEEF);
    run_job(1, 32'h0, 32'h0000_0200, 4, 32'hDEAD_BEEF, -1, 0, 1, 1, 0);
    check("fill_cycles_10", cycles_last, 10);

    // zero length
    build_model(0, 32'h1000, 32'h2000, 0, 32'h0, -1, 0, 1);
    run_job(0, 32'h1000, 32'h2000, 0, 32'h0, -1, 0, 1, 1, 0);
    check("len0_cycles_2", cycles_last, 2);

    // timeout, then a fresh start clears err
    build_model(0, 32'h1000, 32'h2000, 4, 32'h0, -1, 1, -1);
    run_job(0, 32'h1000, 32'h2000, 4, 32'h0, -1, 1, 1, 1, 0);
    check("tmo_cycles_10", cycles_last, 10);
    check("tmo_err_sticky", err, 1'b1);
    build_model(0, 32'h1000, 32'h2000, 2, 32'h0, -1, 0, 1);
    run_job(0, 32'h1000, 32'h2000, 2, 32'h0, -1, 0, 1, 1, 0);

    // abort at completion of the third read
    build_model(0, 32'h3000, 32'h4000, 10, 32'h0, 4, 0, 1);
    check("pin_abort_n", exp_q.size(), 5);
    check("pin_abort_words", exp_words, 2);
    run_job(0, 32'h3000, 32'h4000, 10, 32'h0, 4, 0, 1, 1, 0);

    // address wrap on fill
    build_model(1, 32'h0, 32'hFFFF_FFF8, 3, 32'hCAFE_F00D, -1, 0, 1);
    check("pin_wrap0", exp_q[0].addr, 32'hFFFF_FFF8);
    check("pin_wrap1", exp_q[1].addr, 32'hFFFF_FFFC);
    check("pin_wrap2", exp_q[2].addr, 32'h0000_0000);
    run_job(1, 32'h0, 32'hFFFF_FFF8, 3, 32'hCAFE_F00D, -1, 0, 1, 1, 0);

    // abort while idle is ignored
    build_model(0, 32'h5000, 32'h6000, 2, 32'h0, -1, 0, 1);
    run_job(0, 32'h5000, 32'h6000, 2, 32'h0, -1, 0, 1, 1, 1);

    // asynchronous reset in the middle of a fill
    build_model(1, 32'h0, 32'h300, 6, 32'h1234_5678, -1, 0, 1);
    lat_min = 1; lat_max = 1; tx_idx = 0;
    @(negedge clk);
    start = 1'b1; fill = 1'b1; dst_adr = 32'h300; len = LEN_W'(6); fill_data = 32'h1234_5678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", mem_valid, 1'b1);
    check("pre_rst_wstrb", mem_wstrb, 4'b1111);
    #2 n_reset = 1'b0;
    #1;
    check("midrst_valid", mem_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_addr", mem_addr, 32'h0);
    check("midrst_wdata", mem_wdata, 32'h0);
    check("midrst_wstrb", mem_wstrb, 4'b0000);
    check("midrst_words", words_done, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);
    build_model(0, 32'h7000, 32'h8000, 3, 32'h0, -1, 0, 1);
    run_job(0, 32'h7000, 32'h8000, 3, 32'h0, -1, 0, 1, 1, 0);

    // randomized jobs
    for (int i = 0; i < 40; i++) begin
      f  = 1'($urandom % 2);
      n  = $urandom_range(12, 0);
      s  = (i % 5 == 1) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      d  = (i % 5 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      fd = $urandom;
      if (i % 3 == 0) begin lo = 1; hi = 1; end
      else            begin lo = 0; hi = 4; end
      ab = ($urandom % 4 == 0) ? $urandom_range(2 * n, 0) : -1;
      build_model(f, s, d, n, fd, ab, 0, (lo == hi) ? lo : -1);
      run_job(f, s, d, n, fd, ab, 0, lo, hi, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Word-granular copy/fill engine that acts as a second initiator on the native memory bus (mem_valid/mem_ready handshake), the same bus the CPU and the debug unit drive toward RAM, ROM and MMIO. It reads words from a source range and writes them to a destination range, or writes a constant fill word. Responders pulse ready for one cycle. Bus arbitration is outside this block; its bus outputs are muxed onto the shared bus by the top level.

## Interface
Parameters:
- LEN_W, 16, width of word-count input and progress counter
- TIMEOUT, 255, max cycles mem_valid may wait for mem_ready before error abort (1..2^16-1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_reset  input  1  asynchronous active-low reset
- start  input  1  begin job; sampled only in IDLE
- abort  input  1  stop job at next transaction boundary
- fill  input  1  1 = fill mode (no reads), latched at start
- src_adr  input  32  source byte address, bits [1:0] ignored
- dst_adr  input  32  destination byte address, bits [1:0] ignored
- len  input  LEN_W  number of 32-bit words
- fill_data  input  32  fill word, latched at start
- busy  output  1  job in progress
- done  output  1  one-cycle pulse at job end
- err  output  1  last job ended by timeout; sticky until next start
- words_done  output  LEN_W  words written in current/last job
- mem_valid  output  1  bus request
- mem_instr  output  1  constant 0
- mem_ready  input  1  responder completion pulse
- mem_addr  output  32  bus address, bits [1:0] always 0
- mem_wdata  output  32  write data
- mem_wstrb  output  4  4'b1111 on write, 4'b0000 on read
- mem_rdata  input  32  read data, valid when mem_ready=1

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: start=1 latches src, dst, len, fill, fill_data; clears err and words_done. len=0 goes to FIN. Otherwise go to RD (copy) or WR (fill).
- RD: mem_valid=1, mem_addr=src, mem_wstrb=0. On mem_ready: capture mem_rdata into the data register, src += 4, go to WR.
- WR: mem_valid=1, mem_addr=dst, mem_wdata = data register (copy) or fill_data (fill), mem_wstrb=4'b1111. On mem_ready: dst += 4, words_done += 1, remaining -= 1. If remaining reaches 0 or abort=1, go to FIN. Otherwise go to RD (copy) or stay in WR (fill).
- abort=1 seen at a RD completion also goes to FIN, without writing the word just read. abort in IDLE or FIN is ignored.
- Timeout: a counter clears at each new request and increments while mem_valid=1 and mem_ready=0. When it reaches TIMEOUT: drop mem_valid, set err=1, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- start while busy is ignored, and so are input changes while busy.
- Addresses wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
- mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid=1 and mem_ready=0.

## Timing
- Reset values: busy=0, done=0, err=0, words_done=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, mem_instr=0; state IDLE.
- mem_valid rises in the cycle after the start edge.
- mem_ready is sampled on the rising edge. The request for the next transaction is presented in the cycle immediately after the ready edge (back-to-back, no idle cycle).
- With a responder that raises ready one cycle after valid (registered rdy): 2 cycles per transaction. Copy takes 4·len+2 cycles from start to done, fill takes 2·len+2.
- busy is high from the cycle after start through FIN's predecessor; done and busy are never high together.
- Asynchronous reset mid-job: mem_valid drops immediately, all outputs go to reset values, the job is discarded.

## Test plan
- Copy: src=0x20000, dst=0x00100, len=3, responder ready 1 cycle after valid, source words A,B,C -> bus sequence R20000 W00100=A R20004 W00104=B R20008 W00108=C; done 14 cycles after start; words_done=3, err=0.
- Fill: dst=0x00200, len=4, fill_data=0xDEADBEEF -> 4 writes to 0x200..0x20C with wstrb=1111 and no reads; done 10 cycles after start.
- len=0 -> no mem_valid ever; done pulses 2 cycles after start; words_done=0.
- Timeout: responder never answers, TIMEOUT=8 -> mem_valid high for 8 cycles then low; err=1; done pulse; words_done=0. The next start clears err.
- Abort: copy len=10, abort pulsed during the 3rd read -> that read completes, no 3rd write; done with words_done=2, err=0. Wrap check: dst=0xFFFFFFF8, fill len=3 -> writes to FFFFFFF8, FFFFFFFC, 00000000.
- Reset mid-job: assert n_reset low during a WR with mem_valid=1 -> mem_valid=0 with no clock edge; after release the block is in IDLE and a new start runs normally.
